// File: rtl/lcd_feeder_pkg.sv
// Shared types and default frame geometry for the LCD pixel feeder.
package lcd_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FILL  = 2'd2
  } feeder_state_e;

  localparam int H_ACTIVE         = 480;
  localparam int V_ACTIVE         = 272;
  localparam int FRAME_PIXELS_DEF = H_ACTIVE * V_ACTIVE;

endpackage

// File: rtl/lcd_pixel_feeder_pix_fifo.sv
// pix_fifo: single-clock FIFO with registered read data, flush, and
// simultaneous push/pop. A push into a full FIFO is dropped unless a pop
// frees the slot in the same cycle.
module pix_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic              do_push, do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage array: written only on accepted pushes, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wptr] <= wdata;
  end

  // Pointers, occupancy and the registered read port.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      if (rst) rdata <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop) begin
        rdata <= mem[rptr];
        rptr  <= rptr + AW'(1);
      end
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/lcd_pixel_feeder.sv
// lcd_pixel_feeder: prefetches a frame of RGB565 words from SDRAM in fixed
// bursts into a local FIFO and serves the LCD one pixel per data_req.
// Optional feature macro: LCD_FEEDER_UFCNT_EN adds a saturating 16-bit
// underflow_cnt output.
module lcd_pixel_feeder
  import lcd_feeder_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int DEPTH        = 64,
  parameter int BURST_LEN    = 16,
  parameter int ADDR_W       = 24,
  parameter int FRAME_BASE   = 0,
  parameter int FRAME_PIXELS = FRAME_PIXELS_DEF
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     frame_start,
  output logic                     rd_req,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic                     rd_ack,
  input  logic                     rd_valid,
  input  logic [DATA_W-1:0]        rd_data,
  input  logic                     data_req,
  output logic [DATA_W-1:0]        data_out,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     underflow
`ifdef LCD_FEEDER_UFCNT_EN
  ,
  output logic [15:0]              underflow_cnt
`endif
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int RW = $clog2(FRAME_PIXELS + 1);
  localparam int OW = $clog2(BURST_LEN + 1);

  feeder_state_e     state, state_next;
  logic [ADDR_W-1:0] addr;
  logic [RW-1:0]     remaining;
  logic [OW-1:0]     outstanding, drain_left;
  logic [LW-1:0]     free;
  logic              issue_ok, accept, ufl_hit, zero_out;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;

  assign free       = LW'(DEPTH) - fifo_level;
  // A full FIFO never has room for a burst; the explicit term keeps the
  // issue rule obviously safe against level glitches.
  assign issue_ok   = (state == FILL) && (outstanding == '0) && (remaining != '0) &&
                      !fifo_full && (free >= LW'(BURST_LEN));
  // The request is withdrawn in the frame_start cycle itself; an ack that
  // races it is still honoured as outstanding so its words get drained.
  assign rd_req     = issue_ok & ~frame_start;
  assign accept     = issue_ok & rd_ack;
  assign rd_addr    = addr;
  assign drain_left = outstanding - OW'(rd_valid && outstanding != '0);
  assign ufl_hit    = data_req && fifo_empty && !frame_start;
  assign data_out   = zero_out ? '0 : fifo_rdata;

  pix_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .flush (frame_start),
    .push  (rd_valid && state != DRAIN && !frame_start),
    .wdata (rd_data),
    .pop   (data_req && !frame_start),
    .rdata (fifo_rdata),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_next;
  end

  // Next state. With nothing in flight, frame_start passes straight through
  // DRAIN so the first request appears one cycle later.
  always_comb begin
    state_next = state;
    if (frame_start) begin
      state_next = (accept || drain_left != '0) ? DRAIN : FILL;
    end else begin
      unique case (state)
        DRAIN:   if (outstanding == '0) state_next = FILL;
        FILL:    if (remaining == '0 && outstanding == '0) state_next = IDLE;
        default: state_next = state;
      endcase
    end
  end

  // Burst address, remaining-word and outstanding-word counters.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      addr        <= ADDR_W'(FRAME_BASE);
      remaining   <= '0;
      outstanding <= '0;
    end else begin
      if (accept)                             outstanding <= OW'(BURST_LEN);
      else if (rd_valid && outstanding != '0) outstanding <= outstanding - OW'(1);
      if (frame_start) begin
        addr      <= ADDR_W'(FRAME_BASE);
        remaining <= RW'(FRAME_PIXELS);
      end else if (accept) begin
        addr      <= addr + ADDR_W'(BURST_LEN);
        remaining <= remaining - RW'(BURST_LEN);
      end
    end
  end

  // Sticky underflow flag and output zeroing on empty requests/frame start.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || frame_start) begin
      underflow <= 1'b0;
      zero_out  <= 1'b1;
    end else if (ufl_hit) begin
      underflow <= 1'b1;
      zero_out  <= 1'b1;
    end else if (data_req) begin
      zero_out  <= 1'b0;
    end
  end

`ifdef LCD_FEEDER_UFCNT_EN
  // Saturating count of requests served from an empty FIFO.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || frame_start)               underflow_cnt <= '0;
    else if (ufl_hit && underflow_cnt != '1)  underflow_cnt <= underflow_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_lcd_pixel_feeder.sv
// Scoreboard bench for lcd_pixel_feeder: expected pixels and burst addresses
// are queued by the stimulus, a monitor pops and compares them.
module tb_lcd_pixel_feeder;
  import lcd_feeder_pkg::*;

  localparam int DW = 16, DEPTH = 64, BL = 16, AW = 24, FP = 64;

  logic          clk = 1'b0, rst = 1'b1, frame_start = 1'b0;
  logic          rd_ack = 1'b0, rd_valid = 1'b0, data_req = 1'b0;
  logic [DW-1:0] rd_data = '0;
  logic          rd_req, underflow;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] data_out;
  logic [6:0]    fifo_level;
`ifdef LCD_FEEDER_UFCNT_EN
  logic [15:0]   underflow_cnt;
`endif

  int checks = 0, errors = 0;
  logic [DW-1:0] exp_data[$];
  logic [AW-1:0] exp_addr[$];
  logic          pend = 1'b0;

  always #5 clk = ~clk;

  lcd_pixel_feeder #(.DATA_W(DW), .DEPTH(DEPTH), .BURST_LEN(BL), .ADDR_W(AW),
                     .FRAME_BASE(0), .FRAME_PIXELS(FP)) dut (
    .sys_clk(clk), .sys_rst(rst), .frame_start(frame_start),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .data_req(data_req), .data_out(data_out),
    .fifo_level(fifo_level), .underflow(underflow)
`ifdef LCD_FEEDER_UFCNT_EN
    , .underflow_cnt(underflow_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: sample handshakes at the clock edge, compare pixels half a cycle later.
  always @(posedge clk) begin
    pend <= !rst && data_req && !frame_start;
    if (!rst && rd_ack && rd_req) begin
      if (exp_addr.size() == 0) begin
        checks++; errors++;
        $display("FAIL burst_ack: unexpected burst at %0h", rd_addr);
      end else chk("burst_addr", 32'(rd_addr), 32'(exp_addr.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (pend) begin
      if (exp_data.size() == 0) begin
        checks++; errors++;
        $display("FAIL pixel: unexpected pixel %0h", data_out);
      end else chk("pixel", 32'(data_out), 32'(exp_data.pop_front()));
    end
  end

  task automatic wait_req(input string name);
    int n = 0;
    while (!rd_req && n < 40) begin @(negedge clk); #1; n++; end
    checks++;
    if (!rd_req) begin
      errors++;
      $display("FAIL %s: rd_req not seen within 40 cycles", name);
    end
  endtask

  task automatic ack_burst(input logic [AW-1:0] a, input int delay);
    wait_req("req_before_ack");
    exp_addr.push_back(a);
    repeat (delay) @(negedge clk);
    #1 chk("req_held_addr", 32'(rd_addr), 32'(a));
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
  endtask

  task automatic deliver(input int n, input logic [DW-1:0] base, input bit gap);
    for (int i = 0; i < n; i++) begin
      if (gap && (i % 5) == 3) begin rd_valid = 1'b0; @(negedge clk); end
      rd_valid = 1'b1;
      rd_data  = base + DW'(i);
      @(negedge clk);
    end
    rd_valid = 1'b0;
  endtask

  task automatic request(input int n, input logic [DW-1:0] base, input bit empty_fifo);
    for (int i = 0; i < n; i++) begin
      data_req = 1'b1;
      exp_data.push_back(empty_fifo ? DW'(0) : base + DW'(i));
      @(negedge clk);
    end
    data_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_seen;
    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_rd_req", 32'(rd_req), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
    repeat (2) @(negedge clk);
    #1 chk("idle_no_req", 32'(rd_req), 32'd0);

    // First burst: request one cycle after frame_start, ack after 2 cycles
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    #1;
    chk("fs_req_latency", 32'(rd_req), 32'd1);
    chk("first_addr", 32'(rd_addr), 32'd0);
    ack_burst(24'd0, 2);
    deliver(16, 16'h0001, 1'b0);
    #1;
    chk("level_after_burst", 32'(fifo_level), 32'd16);
    chk("second_req", 32'(rd_req), 32'd1);
    chk("second_addr", 32'(rd_addr), 32'd16);

    // Drain 16 pixels back to back
    request(16, 16'h0001, 1'b0);
    #1;
    chk("no_underflow", 32'(underflow), 32'd0);
    chk("level_drained", 32'(fifo_level), 32'd0);

    // Empty-FIFO requests
    request(1, 16'h0000, 1'b1);
    #1;
    chk("underflow_set", 32'(underflow), 32'd1);
`ifdef LCD_FEEDER_UFCNT_EN
    chk("ufcnt_1", 32'(underflow_cnt), 32'd1);
    request(2, 16'h0000, 1'b1);
    #1 chk("ufcnt_3", 32'(underflow_cnt), 32'd3);
`endif

    // Simultaneous push and pop at level 8
    ack_burst(24'd16, 0);
    deliver(8, 16'h0101, 1'b0);
    #1 chk("level_8", 32'(fifo_level), 32'd8);
    rd_valid = 1'b1; rd_data = 16'h0109; data_req = 1'b1;
    exp_data.push_back(16'h0101);
    @(negedge clk);
    rd_valid = 1'b0; data_req = 1'b0;
    #1 chk("level_push_pop", 32'(fifo_level), 32'd8);
    deliver(7, 16'h010A, 1'b0);
    #1;
    chk("level_15", 32'(fifo_level), 32'd15);
    chk("third_addr", 32'(rd_addr), 32'd32);

    // frame_start with 11 words of an acked burst still in flight
    ack_burst(24'd32, 1);
    deliver(5, 16'h0301, 1'b0);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    #1;
    chk("abort_level", 32'(fifo_level), 32'd0);
    chk("abort_req", 32'(rd_req), 32'd0);
    chk("abort_underflow_clr", 32'(underflow), 32'd0);
    chk("abort_data_out", 32'(data_out), 32'd0);
`ifdef LCD_FEEDER_UFCNT_EN
    chk("abort_ufcnt_clr", 32'(underflow_cnt), 32'd0);
`endif
    deliver(10, 16'h0306, 1'b0);
    #1 chk("drain_no_req", 32'(rd_req), 32'd0);
    deliver(1, 16'h0310, 1'b0);
    #1 chk("drain_discard", 32'(fifo_level), 32'd0);

    // Full frame of 4 bursts with no reads
    for (int b = 0; b < 4; b++) begin
      ack_burst(AW'(b * 16), 1);
      deliver(16, 16'h0200 + DW'(b * 16), 1'b1);
    end
    #1 chk("frame_level", 32'(fifo_level), 32'd64);
    repeat (2) @(negedge clk);
    #1 chk("frame_idle", 32'(dut.state), 32'(IDLE));
    req_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1 if (rd_req) req_seen++;
    end
    chk("no_more_req", 32'(req_seen), 32'd0);
    request(64, 16'h0200, 1'b0);
    #1;
    chk("frame_drained", 32'(fifo_level), 32'd0);
    chk("frame_no_underflow", 32'(underflow), 32'd0);

    repeat (3) @(negedge clk);
    chk("pixels_left", 32'(exp_data.size()), 32'd0);
    chk("bursts_left", 32'(exp_addr.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_pixel_feeder.md
# lcd_pixel_feeder

Prefetching pixel source that sits directly upstream of the LCD top level. It streams a frame of RGB565 words out of the SDRAM read port in fixed-length bursts into a local FIFO. It then serves the LCD's `data_req` strobe with one pixel per request on `data_out`, which feeds the LCD top's `data_in`. A frame-start pulse derived from the LCD's `out_vsync` restarts the address and flushes stale data.

## Interface
Parameters:
- `DATA_W`, 16: pixel width (RGB565).
- `DEPTH`, 64: FIFO depth in words; power of 2, ≥ 2·`BURST_LEN`.
- `BURST_LEN`, 16: words per SDRAM read burst.
- `ADDR_W`, 24: SDRAM word-address width.
- `FRAME_BASE`, 0: word address of pixel (0,0).
- `FRAME_PIXELS`, 130560: words per frame (480×272); must be a multiple of `BURST_LEN`.

Ports:
- `sys_clk` in 1: LCD pixel clock; the only clock.
- `sys_rst` in 1: synchronous, active-high reset.
- `frame_start` in 1: one-cycle pulse at start of vertical blanking.
- `rd_req` out 1: burst read request; held high until acknowledged.
- `rd_addr` out `ADDR_W`: burst start address, stable while `rd_req` is high.
- `rd_ack` in 1: SDRAM accepted the burst.
- `rd_valid` in 1: `rd_data` is valid this cycle.
- `rd_data` in `DATA_W`: burst data.
- `data_req` in 1: LCD requests the next pixel.
- `data_out` out `DATA_W`: pixel, registered.
- `fifo_level` out $clog2(DEPTH)+1: current FIFO occupancy.
- `underflow` out 1: sticky flag; cleared by `frame_start` or reset.

## Operation
- FSM states: IDLE, DRAIN, FILL.
  - IDLE: after reset. No requests are issued. `data_req` returns 0.
  - `frame_start` moves the FSM to DRAIN:
    - FIFO flushed.
    - Address counter := `FRAME_BASE`.
    - Remaining-word counter := `FRAME_PIXELS`.
    - `underflow` cleared.
  - DRAIN: stays here until the outstanding-burst word counter is 0. Words arriving in DRAIN are discarded. Then the FSM goes to FILL.
  - FILL: issues bursts. When the remaining-word counter reaches 0 and the outstanding count is 0, the FSM returns to IDLE; the FIFO keeps serving until empty.
- Burst issue rule: `rd_req` is raised only when all of these hold:
  - state is FILL;
  - no burst is outstanding;
  - remaining > 0;
  - free space (DEPTH − level) ≥ `BURST_LEN`.
- On `rd_ack`:
  - `rd_req` drops the next cycle.
  - Outstanding := `BURST_LEN`.
  - Address += `BURST_LEN`.
  - Remaining −= `BURST_LEN`.
- Every `rd_valid` writes one word to the FIFO (except in DRAIN) and decrements outstanding. Gaps between `rd_valid` cycles are allowed.
- `data_req` with the FIFO non-empty: pop one word; `data_out` is updated at the next edge.
- `data_req` with the FIFO empty: `data_out` := 0, `underflow` := 1, nothing popped.
- Simultaneous push and pop: both take effect; level is unchanged.
- Push while full: cannot occur by the issue rule. If it does occur, the word is dropped and level stays at DEPTH.
- `frame_start` during an outstanding burst: `rd_req` drops immediately, and the words of the burst already acknowledged are drained in DRAIN.
- `frame_start` while `rd_req` is high and not yet acked: the request is withdrawn. SDRAM must not ack in that same cycle; if it does, the ack counts as outstanding and is drained.
- `frame_start` has priority over `data_req` in the same cycle; `data_out` := 0.
- Address arithmetic is unsigned `ADDR_W` and never wraps within a frame.

## Timing
- Reset values:
  - `rd_req` = 0
  - `rd_addr` = `FRAME_BASE`
  - `data_out` = 0
  - `fifo_level` = 0
  - `underflow` = 0
  - state = IDLE
- `data_req` → `data_out` latency: 1 cycle.
- `rd_valid` → word visible in `fifo_level`: 1 cycle; the word can be popped from the following cycle.
- `frame_start` → first `rd_req`: 1 cycle if nothing is outstanding.
- `rd_req`/`rd_ack` is a level/pulse handshake. `rd_addr` holds while `rd_req` = 1.

## Configuration
- `LCD_FEEDER_UFCNT_EN` defined: adds output `underflow_cnt` (16 bits). It counts every `data_req` served while the FIFO is empty, saturates at 16'hFFFF, and is cleared by reset and `frame_start`.
- Not defined: the port and counter are absent; the sticky `underflow` flag alone remains.

## Structure
- `lcd_feeder_pkg`: state enum (IDLE/DRAIN/FILL) and default frame constants (480, 272, `FRAME_PIXELS`).
- Sub-module `pix_fifo`: synchronous single-clock FIFO.
  - Parameters: `DATA_W`, `DEPTH`.
  - Ports: push/pop, level, full/empty.
  - Registered read data; supports simultaneous push and pop.
- Top-level block: FSM, address/remaining/outstanding counters, underflow logic.

## Test plan
- Reset, then `frame_start` with SDRAM acking after 2 cycles and returning 16 words 0x0001..0x0010 → `rd_addr`=0, `fifo_level`=16 after the last `rd_valid`, second `rd_req` at `rd_addr`=16.
- FIFO prefilled with 16 words, `data_req` held high for 16 cycles → `data_out` = 0x0001..0x0010 on consecutive cycles, each one cycle after its request; `underflow` stays 0.
- `data_req` on an empty FIFO → `data_out`=0, `underflow`=1; with `LCD_FEEDER_UFCNT_EN`, `underflow_cnt`=1 and it increments per further empty request.
- `frame_start` after `rd_ack` with 5 of 16 words delivered → remaining 11 words discarded, `fifo_level`=0, next `rd_req` at `FRAME_BASE` only after the 11th word.
- `FRAME_PIXELS`=64, `DEPTH`=64, with `data_req` never asserted → exactly 4 bursts at 0/16/32/48, FSM back in IDLE, `fifo_level`=64, no further `rd_req`.
- Simultaneous `rd_valid` and `data_req` at level 8 → level stays 8 and `data_out` is the oldest word.
